thor2024_iq_sequencer: RTL
==========================

# thor2024_iq_sequencer

Pointer and occupancy controller for the Thor2024 8-entry issue queue. Each cycle it decides how many fetch-buffer instructions (0–2) are enqueued and how many head entries (0–2) retire. It also squashes the wrong path on a branch miss. It supplies the tail0/tail1 indices and enqueue acknowledges consumed by register-source tracking and queue-entry write logic.

## Interface
Parameters:
- QENTRIES, 8, issue-queue depth; must be a power of two.
- QBITS, 3, index width, equal to log2(QENTRIES).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fb0_v, fb1_v  input  1 each  fetch-buffer slot valid.
- fb0_backbr  input  1  fb0 is a backward branch; fb1 must not enqueue alongside it.
- commit0_rdy, commit1_rdy  input  1 each  entry at head0 / head1 has completed.
- branchmiss  input  1  misprediction strobe.
- missid  input  QBITS  queue index of the mispredicted branch.
- tail0, tail1  output  QBITS  next enqueue slots; tail1 == tail0+1 mod QENTRIES always.
- head0, head1  output  QBITS  oldest entries; head1 == head0+1 mod QENTRIES always.
- enq0_ack, enq1_ack  output  1 each  fb0 / fb1 enqueued this cycle (combinational).
- commit0, commit1  output  1 each  head0 / head1 retired this cycle (combinational).
- iq_v  output  QENTRIES  per-entry valid vector (registered).
- count  output  QBITS+1  number of valid entries (registered).
- full, empty  output  1 each  count==QENTRIES / count==0 (registered).
- miss_err  output  1  registered one-cycle pulse, set when branchmiss names an invalid entry.

## Operation
- Enqueue is evaluated against the current registered iq_v. Slot X is free when iq_v[X]==0.
- fb0_v=1:
  - enq0_ack = free(tail0).
  - enq1_ack = enq0_ack & fb1_v & ~fb0_backbr & free(tail1).
- fb0_v=0, fb1_v=1:
  - fb1 takes tail0.
  - enq1_ack = free(tail0); enq0_ack = 0.
- Tail update: tail0 advances by the number of acknowledged instructions, modulo QENTRIES. Enqueued slots set iq_v.
- Commit:
  - commit0 = iq_v[head0] & commit0_rdy.
  - commit1 = commit0 & iq_v[head1] & commit1_rdy.
  - Committed slots clear iq_v; head0 advances by commit count.
- Branch miss, valid case (branchmiss=1 and iq_v[missid]=1):
  - The squash set is the entries from missid+1 up to, but excluding, the pre-edge tail0, with wrap.
  - Squash-set entries clear iq_v; tail0 <= missid+1.
  - enq0_ack = enq1_ack = 0 that cycle.
  - Commits still proceed. The missed branch itself may commit that cycle.
  - If the squash set would include head0 it is empty by construction, because the branch is older than the squash set.
- Branch miss, invalid case (iq_v[missid]=0): no squash, tail unchanged, enqueue proceeds normally, miss_err=1 next cycle.
- count_next = popcount(iq_v_next). full and empty are derived from count_next and registered.
- A slot freed by commit in cycle N is not enqueueable until cycle N+1. Same-cycle reuse is forbidden.

## Timing
- Reset (async, rst_n low):
  - tail0=0, tail1=1, head0=0, head1=1.
  - iq_v=0, count=0, empty=1, full=0, miss_err=0.
  - Reset asserted mid-operation discards all entries immediately.
- enq*_ack and commit* are combinational from registered state and the inputs of the current cycle. The resulting pointer, iq_v and count updates are visible one cycle later.
- Enqueue-to-commit minimum latency: 1 cycle; an entry enqueued at edge N may commit in cycle N+1.
- With full=1 no enqueue occurs. A commit in that cycle does not enable enqueue until the next cycle.

## Structure
- Thor2024pkg holds QENTRIES, QBITS and the typedef que_ndx_t (logic [QBITS-1:0]). The existing package constants are reused.
- Sub-module thor2024_iq_squash_mask: combinational. Inputs are missid, tail0 and iq_v; output is a QENTRIES-bit wrap-aware squash mask. Kept separate so it can be verified exhaustively (8×8 index pairs).
- Popcount is inline.

## Test plan
- Reset, then fb0_v=fb1_v=1 for 4 cycles with no commits:
  - Each cycle acks both.
  - Tail sequence 0→2→4→6→0.
  - full=1 after cycle 4; cycle 5 acks none.
- Queue full, commit0_rdy=commit1_rdy=1 at head0=0:
  - Cycle N: commit0=commit1=1.
  - Cycle N+1: head0=2, count=6.
  - Enqueue acks in N+1 refill slots 0,1.
- fb0_backbr=1 with fb0_v=fb1_v=1 and empty queue: enq0_ack=1, enq1_ack=0, tail0 0→1.
- Wrap squash:
  - Setup: head0=5, tail0=2, entries 5,6,7,0,1 valid.
  - Stimulus: branchmiss, missid=7.
  - Next cycle: iq_v[0]=iq_v[1]=0, tail0=0, count=3; no enqueue in the miss cycle.
- branchmiss with missid=5 (=head0) and commit0_rdy=1 in the same cycle:
  - Branch commits; entries 6..tail-1 are squashed.
  - Next cycle: head0=6, tail0=6, empty=1.
- branchmiss with missid pointing at an invalid slot: state unchanged except normal enqueue/commit; miss_err pulses for one cycle.

Source files
------------

// File: rtl/thor2024_iq_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// thor2024_iq_sequencer_pkg
//   Shared sizing constants and index type for the Thor2024 issue queue
//   pointer/occupancy logic.
//   QENTRIES : issue-queue depth (power of two)
//   QBITS    : index width, log2(QENTRIES)
//   que_ndx_t: queue index type
// ---------------------------------------------------------------------------
package thor2024_iq_sequencer_pkg;

  localparam int QENTRIES = 8;
  localparam int QBITS    = 3;

  typedef logic [QBITS-1:0] que_ndx_t;

  // Modulo-QENTRIES successor of a queue index. Relies on QENTRIES being a
  // power of two so the natural wrap of the index width is the modulo.
  function automatic que_ndx_t ndx_next(input que_ndx_t ndx);
    return ndx + que_ndx_t'(1);
  endfunction

endpackage

// File: rtl/thor2024_iq_sequencer_squash.sv
// ---------------------------------------------------------------------------
// thor2024_iq_squash_mask
//   Combinational wrap-aware squash mask for a branch misprediction.
//   An entry is flagged when it lies strictly after missid and strictly
//   before tail0 (walking forward with wrap) and is currently valid.
//   Ports:
//     missid      in  queue index of the mispredicted branch
//     tail0       in  current (pre-edge) enqueue pointer
//     iq_v        in  registered per-entry valid vector
//     squash_mask out entries to be discarded
// ---------------------------------------------------------------------------
module thor2024_iq_squash_mask #(
  parameter int QENTRIES = 8,
  parameter int QBITS    = 3
) (
  input  logic [QBITS-1:0]    missid,
  input  logic [QBITS-1:0]    tail0,
  input  logic [QENTRIES-1:0] iq_v,
  output logic [QENTRIES-1:0] squash_mask
);

  localparam logic [QBITS-1:0] ONE = QBITS'(1);

  logic [QBITS-1:0] span;
  logic [QBITS-1:0] ofs;

  // Distances are measured from missid+1; an entry is inside the younger
  // window when its distance is below the window length. When tail0 is
  // missid+1 the window length is zero and nothing is squashed.
  always_comb begin
    span        = tail0 - missid - ONE;
    ofs         = '0;
    squash_mask = '0;
    for (int i = 0; i < QENTRIES; i++) begin
      ofs            = QBITS'(i) - missid - ONE;
      squash_mask[i] = iq_v[i] & (ofs < span);
    end
  end

endmodule

// File: rtl/thor2024_iq_sequencer.sv
// ---------------------------------------------------------------------------
// thor2024_iq_sequencer
//   Pointer and occupancy controller for the Thor2024 issue queue. Decides
//   per cycle how many fetch-buffer instructions (0-2) enqueue, how many
//   head entries (0-2) retire, and squashes the wrong path on a valid
//   branch miss.
//   Ports:
//     clk, rst_n              clock, async active-low reset
//     fb0_v, fb1_v            fetch-buffer slot valid
//     fb0_backbr              fb0 is a backward branch (blocks fb1 pairing)
//     commit0_rdy/commit1_rdy head0/head1 entry completed
//     branchmiss, missid      misprediction strobe and branch index
//     tail0, tail1            next enqueue slots (tail1 = tail0+1)
//     head0, head1            oldest entries (head1 = head0+1)
//     enq0_ack, enq1_ack      fb0/fb1 enqueued this cycle (combinational)
//     commit0, commit1        head0/head1 retired this cycle (combinational)
//     iq_v, count             registered valid vector and occupancy
//     full, empty             registered occupancy flags
//     miss_err                one-cycle pulse: miss named an invalid entry
// ---------------------------------------------------------------------------
module thor2024_iq_sequencer
  import thor2024_iq_sequencer_pkg::*;
#(
  parameter int QENTRIES = thor2024_iq_sequencer_pkg::QENTRIES,
  parameter int QBITS    = thor2024_iq_sequencer_pkg::QBITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fb0_v,
  input  logic                fb1_v,
  input  logic                fb0_backbr,
  input  logic                commit0_rdy,
  input  logic                commit1_rdy,
  input  logic                branchmiss,
  input  logic [QBITS-1:0]    missid,
  output logic [QBITS-1:0]    tail0,
  output logic [QBITS-1:0]    tail1,
  output logic [QBITS-1:0]    head0,
  output logic [QBITS-1:0]    head1,
  output logic                enq0_ack,
  output logic                enq1_ack,
  output logic                commit0,
  output logic                commit1,
  output logic [QENTRIES-1:0] iq_v,
  output logic [QBITS:0]      count,
  output logic                full,
  output logic                empty,
  output logic                miss_err
);

  localparam logic [QBITS-1:0] ONE = QBITS'(1);

  logic [QBITS-1:0]    tail0_q, tail0_d;
  logic [QBITS-1:0]    head0_q, head0_d;
  logic [QENTRIES-1:0] iq_v_q, iq_v_d;
  logic [QBITS:0]      count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                miss_err_q, miss_err_d;

  logic [QBITS-1:0]    tail1_w;
  logic [QBITS-1:0]    head1_w;
  logic                miss_vld;
  logic [QENTRIES-1:0] squash_raw;
  logic [QENTRIES-1:0] squash_mask;
  logic [QENTRIES-1:0] enq_mask;
  logic [QENTRIES-1:0] commit_mask;
  logic [1:0]          enq_cnt;
  logic [1:0]          commit_cnt;

  assign tail1_w  = tail0_q + ONE;
  assign head1_w  = head0_q + ONE;
  assign miss_vld = branchmiss & iq_v_q[missid];

  thor2024_iq_squash_mask #(
    .QENTRIES (QENTRIES),
    .QBITS    (QBITS)
  ) u_squash_mask (
    .missid      (missid),
    .tail0       (tail0_q),
    .iq_v        (iq_v_q),
    .squash_mask (squash_raw)
  );

  assign squash_mask = miss_vld ? squash_raw : '0;

  // Enqueue decision. Freeness is judged only on the registered valid
  // vector, so a slot retired this cycle cannot be refilled until the next.
  always_comb begin
    enq0_ack = 1'b0;
    enq1_ack = 1'b0;
    if (!miss_vld) begin
      if (fb0_v) begin
        enq0_ack = ~iq_v_q[tail0_q];
        enq1_ack = ~iq_v_q[tail0_q] & fb1_v & ~fb0_backbr & ~iq_v_q[tail1_w];
      end else if (fb1_v) begin
        enq1_ack = ~iq_v_q[tail0_q];
      end
    end
  end

  always_comb begin
    commit0 = iq_v_q[head0_q] & commit0_rdy;
    commit1 = iq_v_q[head0_q] & commit0_rdy & iq_v_q[head1_w] & commit1_rdy;
  end

  // fb1 lands in tail1 only when fb0 also enqueued; a lone fb1 takes tail0.
  always_comb begin
    enq_mask = '0;
    if (enq0_ack) begin
      enq_mask[tail0_q] = 1'b1;
    end
    if (enq1_ack) begin
      if (fb0_v) begin
        enq_mask[tail1_w] = 1'b1;
      end else begin
        enq_mask[tail0_q] = 1'b1;
      end
    end
  end

  always_comb begin
    commit_mask = '0;
    if (commit0) begin
      commit_mask[head0_q] = 1'b1;
    end
    if (commit1) begin
      commit_mask[head1_w] = 1'b1;
    end
  end

  assign enq_cnt    = {1'b0, enq0_ack} + {1'b0, enq1_ack};
  assign commit_cnt = {1'b0, commit0} + {1'b0, commit1};

  always_comb begin
    iq_v_d     = (iq_v_q & ~squash_mask & ~commit_mask) | enq_mask;
    tail0_d    = miss_vld ? (missid + ONE) : (tail0_q + QBITS'(enq_cnt));
    head0_d    = head0_q + QBITS'(commit_cnt);
    miss_err_d = branchmiss & ~iq_v_q[missid];
    count_d    = '0;
    for (int i = 0; i < QENTRIES; i++) begin
      count_d = count_d + (QBITS+1)'(iq_v_d[i]);
    end
    full_d  = (count_d == (QBITS+1)'(QENTRIES));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail0_q    <= '0;
      head0_q    <= '0;
      iq_v_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      miss_err_q <= 1'b0;
    end else begin
      tail0_q    <= tail0_d;
      head0_q    <= head0_d;
      iq_v_q     <= iq_v_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      miss_err_q <= miss_err_d;
    end
  end

  assign tail0    = tail0_q;
  assign tail1    = tail1_w;
  assign head0    = head0_q;
  assign head1    = head1_w;
  assign iq_v     = iq_v_q;
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign miss_err = miss_err_q;

endmodule
